// File: rtl/spis_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the shared CPU bus; optional parity via SPIS_UART_TX_PARITY_EN.
// Latency: byte pushed at edge N leaves as a start bit from edge N+1 when idle and enabled.
// Backpressure: none on the bus; a push into a full FIFO is dropped and sets sticky overflow.
module spis_uart_tx #(
    parameter logic [11:0] BASE_ADDRESS = 12'hFF0,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        resetN,
    inout  wire  [7:0]  dataBus,
    input  logic [11:0] addressBus,
    input  logic        write,
    input  logic        sync,
    output logic        txd,
    output logic        txBusy
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);

`ifdef SPIS_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity_en;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [BCW-1:0]  bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            enable;
    logic            overflow;
    logic            sel;
    logic            data_wr;
    logic            ctrl_wr;
    logic            fifo_clr;
    logic            empty;
    logic            full;
    logic            bit_end;
    logic            pop;
    logic            push_ok;
    logic            frame_next;
    logic [7:0]      rdata;

    assign sel      = (addressBus[11:2] == BASE_ADDRESS[11:2]) && !sync;
    assign data_wr  = sel && write && (addressBus[1:0] == 2'd0);
    assign ctrl_wr  = sel && write && (addressBus[1:0] == 2'd2);
    assign fifo_clr = ctrl_wr && dataBus[1];
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign bit_end  = (bit_cnt == BCW'(CLKS_PER_BIT - 1));
    // Pop either from idle or on the last stop-bit clock, so back-to-back frames have no gap.
    assign pop      = enable && !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign push_ok  = data_wr && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (fifo_clr)
            count_nxt = '0;
        else if (push_ok && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push_ok)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        frame_next = (state != IDLE);
        if (pop)
            frame_next = 1'b1;
        else if ((state == STOP) && bit_end)
            frame_next = 1'b0;
    end

    always_comb begin
        rdata = 8'h00;
        case (addressBus[1:0])
            2'd1: rdata = {4'(count), overflow, (state != IDLE), full, empty};
`ifdef SPIS_UART_TX_PARITY_EN
            2'd2: rdata = {4'b0, parity_en, 2'b0, enable};
`else
            2'd2: rdata = {7'b0, enable};
`endif
            default: rdata = 8'h00;
        endcase
    end

    assign dataBus = (sel && !write) ? rdata : 8'bz;

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= dataBus;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            enable    <= 1'b1;
            overflow  <= 1'b0;
`ifdef SPIS_UART_TX_PARITY_EN
            parity_en <= 1'b1;
`endif
        end else begin
            count <= count_nxt;
            if (fifo_clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
            end
            if (ctrl_wr && dataBus[2])
                overflow <= 1'b0;
            else if (data_wr && full && !pop)
                overflow <= 1'b1;
            if (ctrl_wr) begin
                enable    <= dataBus[0];
`ifdef SPIS_UART_TX_PARITY_EN
                parity_en <= dataBus[3];
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
            txBusy  <= 1'b0;
        end else begin
            txBusy <= frame_next || (count_nxt != '0);
            if (state != IDLE)
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        txd     <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef SPIS_UART_TX_PARITY_EN
                            if (parity_en) begin
                                txd   <= ^shift;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef SPIS_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
